// File: rtl/sdr_init_monitor_if.sv
// SDRAM pad-side command bus seen by the init monitor.
//   sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n : SDRAM command pins
//   sdr_init_done                            : controller init-complete flag
// master : whoever drives the pads (controller or bench)
// slave  : passive observer (sdr_init_monitor)
interface sdr_init_monitor_if;
    logic sdr_cs_n;
    logic sdr_ras_n;
    logic sdr_cas_n;
    logic sdr_we_n;
    logic sdr_init_done;

    modport master (
        output sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n, sdr_init_done
    );

    modport slave (
        input sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n, sdr_init_done
    );
endinterface

// File: rtl/sdr_init_monitor.sv
// SDRAM power-up sequence checker. Watches the pad-side command bus and the
// controller's init-done flag and checks: NOP wait, PRECHARGE-ALL, N x
// AUTO-REFRESH spaced by tRFC, LOAD MODE REGISTER, then init-done within a
// bounded window. Reports sticky pass/fail and the first error code.
//
// Ports:
//   sdram_clk     in   monitor clock
//   sdram_resetn  in   asynchronous active-low reset
//   bus           slave modport of sdr_init_monitor_if (command pins + done)
//   init_ok       out  sticky, sequence completed legally
//   init_err      out  sticky, violation detected
//   err_code[2:0] out  first violation: 0 none, 1 NOP_SHORT, 2 BAD_CMD,
//                      3 TRFC, 4 AR_FEW, 5 TIMEOUT, 6 EARLY_DONE
//   ar_count[3:0] out  AUTO-REFRESH commands accepted, saturates at 15
//   mon_state[2:0] out current FSM state
//
// Optional build macro SDR_INIT_MON_STATS_EN adds:
//   stat_nop_cycles[15:0] out  NOP count captured at PRECHARGE
//   stat_lmr_to_done[7:0] out  cycles from LMR to init-done
//
// state    | meaning
// ---------+-----------------------------------------------
// WAIT_NOP | counting power-up NOPs, waiting for PRECHARGE
// REFRESH  | PRECHARGE seen, accepting AUTO-REFRESH / LMR
// MRD      | LMR seen, waiting for sdr_init_done
// DONE     | sequence legal, absorbing until reset
// ERROR    | violation latched, absorbing until reset
module sdr_init_monitor #(
    parameter int unsigned MIN_NOP_CYCLES = 505,
    parameter int unsigned MIN_AR_CMDS    = 2,
    parameter int unsigned TRFC_CYCLES    = 7,
    parameter int unsigned DONE_TIMEOUT   = 16
) (
    input  logic                  sdram_clk,
    input  logic                  sdram_resetn,
    sdr_init_monitor_if.slave     bus,
    output logic                  init_ok,
    output logic                  init_err,
    output logic [2:0]            err_code,
    output logic [3:0]            ar_count,
    output logic [2:0]            mon_state
`ifdef SDR_INIT_MON_STATS_EN
    ,
    output logic [15:0]           stat_nop_cycles,
    output logic [7:0]            stat_lmr_to_done
`endif
);

    localparam logic [2:0] S_WAIT_NOP = 3'd0;
    localparam logic [2:0] S_REFRESH  = 3'd1;
    localparam logic [2:0] S_MRD      = 3'd2;
    localparam logic [2:0] S_DONE     = 3'd3;
    localparam logic [2:0] S_ERROR    = 3'd4;

    localparam logic [2:0] E_NONE       = 3'd0;
    localparam logic [2:0] E_NOP_SHORT  = 3'd1;
    localparam logic [2:0] E_BAD_CMD    = 3'd2;
    localparam logic [2:0] E_TRFC       = 3'd3;
    localparam logic [2:0] E_AR_FEW     = 3'd4;
    localparam logic [2:0] E_TIMEOUT    = 3'd5;
    localparam logic [2:0] E_EARLY_DONE = 3'd6;

    localparam logic [15:0] MIN_NOP_L  = 16'(MIN_NOP_CYCLES);
    localparam logic [3:0]  MIN_AR_L   = 4'(MIN_AR_CMDS);
    localparam logic [7:0]  TRFC_L     = 8'(TRFC_CYCLES);
    localparam logic [7:0]  DONE_TO_L  = 8'(DONE_TIMEOUT);
    localparam logic [7:0]  TMO_LIMIT  = 8'(DONE_TIMEOUT + 1);

    logic [2:0]  state_q, state_d;
    logic [15:0] nop_cnt_q, nop_cnt_d;
    logic [7:0]  gap_cnt_q, gap_cnt_d;
    logic [7:0]  tmo_cnt_q, tmo_cnt_d;
    logic [3:0]  ar_cnt_q, ar_cnt_d;
    logic        init_ok_q, init_ok_d;
    logic        init_err_q, init_err_d;
    logic [2:0]  err_code_q, err_code_d;
`ifdef SDR_INIT_MON_STATS_EN
    logic [15:0] stat_nop_q, stat_nop_d;
    logic [7:0]  stat_lmr_q, stat_lmr_d;
`endif

    logic [3:0] cmd;
    logic       is_nop, is_pre, is_ar, is_lmr;
    logic       err_set;
    logic [2:0] err_new;
    logic [7:0] elapsed;

    // Deselect counts as NOP regardless of the other pins.
    always_comb begin
        cmd    = {bus.sdr_cs_n, bus.sdr_ras_n, bus.sdr_cas_n, bus.sdr_we_n};
        is_nop = bus.sdr_cs_n || (cmd == 4'b0111);
        is_pre = (cmd == 4'b0010);
        is_ar  = (cmd == 4'b0001);
        is_lmr = (cmd == 4'b0000);
    end

    always_comb begin
        state_d    = state_q;
        nop_cnt_d  = nop_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        tmo_cnt_d  = tmo_cnt_q;
        ar_cnt_d   = ar_cnt_q;
        init_ok_d  = init_ok_q;
        init_err_d = init_err_q;
        err_code_d = err_code_q;
        err_set    = 1'b0;
        err_new    = E_NONE;
        elapsed    = tmo_cnt_q + 8'd1;
`ifdef SDR_INIT_MON_STATS_EN
        stat_nop_d = stat_nop_q;
        stat_lmr_d = stat_lmr_q;
`endif

        if (is_pre || is_ar || is_lmr) begin
            gap_cnt_d = 8'd0;
        end else if (is_nop && gap_cnt_q != 8'hFF) begin
            gap_cnt_d = gap_cnt_q + 8'd1;
        end

        case (state_q)
            S_WAIT_NOP: begin
                if (is_nop) begin
                    if (nop_cnt_q != 16'hFFFF) nop_cnt_d = nop_cnt_q + 16'd1;
                end else begin
                    nop_cnt_d = 16'd0;
                end
                // Early done outranks any command error in the same cycle.
                if (bus.sdr_init_done) begin
                    err_set = 1'b1;
                    err_new = E_EARLY_DONE;
                end else if (is_pre) begin
`ifdef SDR_INIT_MON_STATS_EN
                    stat_nop_d = nop_cnt_q;
`endif
                    if (nop_cnt_q >= MIN_NOP_L) begin
                        state_d = S_REFRESH;
                    end else begin
                        err_set = 1'b1;
                        err_new = E_NOP_SHORT;
                    end
                end else if (!is_nop) begin
                    err_set = 1'b1;
                    err_new = E_BAD_CMD;
                end
            end
            S_REFRESH: begin
                if (bus.sdr_init_done) begin
                    err_set = 1'b1;
                    err_new = E_EARLY_DONE;
                end else if (is_ar) begin
                    if (gap_cnt_q >= TRFC_L) begin
                        if (ar_cnt_q != 4'hF) ar_cnt_d = ar_cnt_q + 4'd1;
                    end else begin
                        err_set = 1'b1;
                        err_new = E_TRFC;
                    end
                end else if (is_lmr) begin
                    // tRFC violation is reported ahead of too-few refreshes.
                    if (gap_cnt_q < TRFC_L) begin
                        err_set = 1'b1;
                        err_new = E_TRFC;
                    end else if (ar_cnt_q < MIN_AR_L) begin
                        err_set = 1'b1;
                        err_new = E_AR_FEW;
                    end else begin
                        state_d   = S_MRD;
                        tmo_cnt_d = 8'd0;
                    end
                end else if (!is_nop) begin
                    err_set = 1'b1;
                    err_new = E_BAD_CMD;
                end
            end
            S_MRD: begin
                // elapsed = cycles since the edge that sampled LMR
                tmo_cnt_d = elapsed;
                if (!is_nop) begin
                    err_set = 1'b1;
                    err_new = E_BAD_CMD;
                end else if (bus.sdr_init_done && elapsed <= DONE_TO_L) begin
                    state_d   = S_DONE;
                    init_ok_d = 1'b1;
`ifdef SDR_INIT_MON_STATS_EN
                    stat_lmr_d = elapsed;
`endif
                end else if (elapsed >= TMO_LIMIT) begin
                    err_set = 1'b1;
                    err_new = E_TIMEOUT;
                end
            end
            default: begin
                // DONE and ERROR hold everything until reset.
            end
        endcase

        // ERROR is absorbing, so only the first violation ever gets here.
        if (err_set) begin
            state_d    = S_ERROR;
            init_err_d = 1'b1;
            err_code_d = err_new;
        end
    end

    always_ff @(posedge sdram_clk or negedge sdram_resetn) begin
        if (!sdram_resetn) begin
            state_q    <= S_WAIT_NOP;
            nop_cnt_q  <= 16'd0;
            gap_cnt_q  <= 8'd0;
            tmo_cnt_q  <= 8'd0;
            ar_cnt_q   <= 4'd0;
            init_ok_q  <= 1'b0;
            init_err_q <= 1'b0;
            err_code_q <= E_NONE;
`ifdef SDR_INIT_MON_STATS_EN
            stat_nop_q <= 16'd0;
            stat_lmr_q <= 8'd0;
`endif
        end else begin
            state_q    <= state_d;
            nop_cnt_q  <= nop_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            tmo_cnt_q  <= tmo_cnt_d;
            ar_cnt_q   <= ar_cnt_d;
            init_ok_q  <= init_ok_d;
            init_err_q <= init_err_d;
            err_code_q <= err_code_d;
`ifdef SDR_INIT_MON_STATS_EN
            stat_nop_q <= stat_nop_d;
            stat_lmr_q <= stat_lmr_d;
`endif
        end
    end

    assign init_ok   = init_ok_q;
    assign init_err  = init_err_q;
    assign err_code  = err_code_q;
    assign ar_count  = ar_cnt_q;
    assign mon_state = state_q;
`ifdef SDR_INIT_MON_STATS_EN
    assign stat_nop_cycles  = stat_nop_q;
    assign stat_lmr_to_done = stat_lmr_q;
`endif

endmodule
